// File: rtl/game_sequencer.sv
// Round controller for the Zoordian game: credit-gated start, pattern load wait,
// guess/grade rounds, and the win/loss decision. All outputs are registered (1-cycle latency).
// Inputs are not backpressured; a GuessSubmit or GradeDone that arrives in the wrong state is dropped.
//
// Ports:
//   CLOCK_50, reset (async, active-low)
//   roundReady, NumRounds      : coin credit status and credited round count
//   StartButton                : player start/ack level; rising edge detected internally
//   patternReady               : master pattern loaded
//   GuessSubmit, GradeDone     : one-cycle pulses from player and grader
//   Znarly                     : exact-match count from grader
//   StartGame, GradeIt, GuessAccept, RoundNumber, RoundsLeft, GameWon, GameOver, state
module game_sequencer #(
  parameter int MAX_ROUNDS = 8,
  parameter int NUM_SHAPES = 4
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       roundReady,
  input  logic [4:0] NumRounds,
  input  logic       StartButton,
  input  logic       patternReady,
  input  logic       GuessSubmit,
  input  logic       GradeDone,
  input  logic [3:0] Znarly,
  output logic       StartGame,
  output logic       GradeIt,
  output logic       GuessAccept,
  output logic [3:0] RoundNumber,
  output logic [4:0] RoundsLeft,
  output logic       GameWon,
  output logic       GameOver,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    PLAY  = 3'd2,
    GRADE = 3'd3,
    WIN   = 3'd4,
    LOSE  = 3'd5
  } state_t;

  localparam logic [4:0] MAX_R   = MAX_ROUNDS[4:0];
  localparam logic [3:0] WIN_CNT = NUM_SHAPES[3:0];

  state_t st;
  logic   start_prev;
  logic   start_edge;

  assign start_edge = StartButton & ~start_prev;
  assign state      = st;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      st          <= IDLE;
      start_prev  <= 1'b0;
      StartGame   <= 1'b0;
      GradeIt     <= 1'b0;
      GuessAccept <= 1'b0;
      RoundNumber <= 4'd0;
      RoundsLeft  <= 5'd0;
      GameWon     <= 1'b0;
      GameOver    <= 1'b0;
    end else begin
      start_prev  <= StartButton;
      // Handshake strobes are single-cycle unless re-asserted below.
      GradeIt     <= 1'b0;
      GuessAccept <= 1'b0;

      case (st)
        IDLE: begin
          if (start_edge && roundReady && (NumRounds != 5'd0)) begin
            st         <= LOAD;
            StartGame  <= 1'b1;
            RoundsLeft <= (NumRounds > MAX_R) ? MAX_R : NumRounds;
          end
        end

        LOAD: begin
          if (patternReady) begin
            st          <= PLAY;
            RoundNumber <= 4'd1;
          end
        end

        PLAY: begin
          if (GuessSubmit) begin
            st          <= GRADE;
            GradeIt     <= 1'b1;
            GuessAccept <= 1'b1;
          end
        end

        GRADE: begin
          if (GradeDone) begin
            if (Znarly >= WIN_CNT) begin
              // A win takes priority over budget exhaustion on the last round.
              st        <= WIN;
              StartGame <= 1'b0;
              GameWon   <= 1'b1;
              GameOver  <= 1'b1;
            end else begin
              if (RoundsLeft != 5'd0) begin
                RoundsLeft <= RoundsLeft - 5'd1;
              end
              if (RoundsLeft <= 5'd1) begin
                st        <= LOSE;
                StartGame <= 1'b0;
                GameOver  <= 1'b1;
              end else begin
                st          <= PLAY;
                RoundNumber <= RoundNumber + 4'd1;
              end
            end
          end
        end

        WIN, LOSE: begin
          // Acknowledge only returns to IDLE; a fresh edge is needed to start again.
          if (start_edge) begin
            st          <= IDLE;
            GameWon     <= 1'b0;
            GameOver    <= 1'b0;
            RoundNumber <= 4'd0;
            RoundsLeft  <= 5'd0;
          end
        end

        default: begin
          st          <= IDLE;
          StartGame   <= 1'b0;
          RoundNumber <= 4'd0;
          RoundsLeft  <= 5'd0;
          GameWon     <= 1'b0;
          GameOver    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed, table-driven bench for game_sequencer: one vector per clock cycle,
// outputs sampled 1 time unit after the rising edge, plus a hand-written
// asynchronous-reset-in-GRADE sequence.
module tb_game_sequencer;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       roundReady;
  logic [4:0] NumRounds;
  logic       StartButton;
  logic       patternReady;
  logic       GuessSubmit;
  logic       GradeDone;
  logic [3:0] Znarly;
  logic       StartGame;
  logic       GradeIt;
  logic       GuessAccept;
  logic [3:0] RoundNumber;
  logic [4:0] RoundsLeft;
  logic       GameWon;
  logic       GameOver;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  game_sequencer #(.MAX_ROUNDS(8), .NUM_SHAPES(4)) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .roundReady  (roundReady),
    .NumRounds   (NumRounds),
    .StartButton (StartButton),
    .patternReady(patternReady),
    .GuessSubmit (GuessSubmit),
    .GradeDone   (GradeDone),
    .Znarly      (Znarly),
    .StartGame   (StartGame),
    .GradeIt     (GradeIt),
    .GuessAccept (GuessAccept),
    .RoundNumber (RoundNumber),
    .RoundsLeft  (RoundsLeft),
    .GameWon     (GameWon),
    .GameOver    (GameOver),
    .state       (state)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Packed expected-output layout: {sg, gi, ga, rn[3:0], rl[4:0], gw, go, st[2:0]}
  typedef struct packed {
    logic        rr;
    logic [4:0]  nr;
    logic        sb;
    logic        pr;
    logic        gs;
    logic        gd;
    logic [3:0]  zn;
    logic [16:0] exp;
  } vec_t;

  localparam int NV = 32;
  vec_t vecs [NV];

  function automatic logic [16:0] mk_exp(
    input logic sg, input logic gi, input logic ga, input logic [3:0] rn,
    input logic [4:0] rl, input logic gw, input logic go, input logic [2:0] st);
    return {sg, gi, ga, rn, rl, gw, go, st};
  endfunction

  function automatic vec_t mkv(
    input logic rr, input logic [4:0] nr, input logic sb, input logic pr,
    input logic gs, input logic gd, input logic [3:0] zn,
    input logic sg, input logic gi, input logic ga, input logic [3:0] rn,
    input logic [4:0] rl, input logic gw, input logic go, input logic [2:0] st);
    vec_t v;
    v.rr = rr; v.nr = nr; v.sb = sb; v.pr = pr; v.gs = gs; v.gd = gd; v.zn = zn;
    v.exp = mk_exp(sg, gi, ga, rn, rl, gw, go, st);
    return v;
  endfunction

  function automatic logic [16:0] observed();
    return {StartGame, GradeIt, GuessAccept, RoundNumber, RoundsLeft, GameWon, GameOver, state};
  endfunction

  task automatic drive(input logic rr, input logic [4:0] nr, input logic sb, input logic pr,
                       input logic gs, input logic gd, input logic [3:0] zn);
    roundReady = rr; NumRounds = nr; StartButton = sb; patternReady = pr;
    GuessSubmit = gs; GradeDone = gd; Znarly = zn;
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check(input string name, input logic [16:0] exp);
    logic [16:0] got;
    got = observed();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got sg=%0b gi=%0b ga=%0b rn=%0d rl=%0d gw=%0b go=%0b st=%0d, expected sg=%0b gi=%0b ga=%0b rn=%0d rl=%0d gw=%0b go=%0b st=%0d",
               name, got[16], got[15], got[14], got[13:10], got[9:5], got[4], got[3], got[2:0],
               exp[16], exp[15], exp[14], exp[13:10], exp[9:5], exp[4], exp[3], exp[2:0]);
    end
  endtask

  initial begin
    //                rr nr     sb pr gs gd zn     | sg gi ga rn     rl     gw go st
    // No credit: start edge ignored
    vecs[0]  = mkv(0, 5'd0,  1, 0, 0, 0, 4'd0,  0, 0, 0, 4'd0, 5'd0, 0, 0, 3'd0);
    vecs[1]  = mkv(0, 5'd0,  0, 0, 0, 0, 4'd0,  0, 0, 0, 4'd0, 5'd0, 0, 0, 3'd0);
    // Credit 12 clamped to 8
    vecs[2]  = mkv(1, 5'd12, 1, 0, 0, 0, 4'd0,  1, 0, 0, 4'd0, 5'd8, 0, 0, 3'd1);
    vecs[3]  = mkv(1, 5'd12, 1, 0, 0, 0, 4'd0,  1, 0, 0, 4'd0, 5'd8, 0, 0, 3'd1);
    // Guess/grade pulses ignored in LOAD
    vecs[4]  = mkv(1, 5'd12, 0, 0, 1, 1, 4'd4,  1, 0, 0, 4'd0, 5'd8, 0, 0, 3'd1);
    vecs[5]  = mkv(1, 5'd12, 0, 1, 0, 0, 4'd0,  1, 0, 0, 4'd1, 5'd8, 0, 0, 3'd2);
    // GradeDone ignored in PLAY
    vecs[6]  = mkv(1, 5'd12, 0, 1, 0, 1, 4'd4,  1, 0, 0, 4'd1, 5'd8, 0, 0, 3'd2);
    vecs[7]  = mkv(1, 5'd12, 0, 1, 1, 0, 4'd0,  1, 1, 1, 4'd1, 5'd8, 0, 0, 3'd3);
    // Second guess in GRADE gets no accept
    vecs[8]  = mkv(1, 5'd12, 0, 1, 1, 0, 4'd0,  1, 0, 0, 4'd1, 5'd8, 0, 0, 3'd3);
    vecs[9]  = mkv(1, 5'd12, 0, 1, 0, 1, 4'd2,  1, 0, 0, 4'd2, 5'd7, 0, 0, 3'd2);
    vecs[10] = mkv(1, 5'd12, 0, 1, 1, 0, 4'd0,  1, 1, 1, 4'd2, 5'd7, 0, 0, 3'd3);
    vecs[11] = mkv(1, 5'd12, 0, 1, 0, 0, 4'd0,  1, 0, 0, 4'd2, 5'd7, 0, 0, 3'd3);
    // Win: counters frozen
    vecs[12] = mkv(1, 5'd12, 0, 1, 0, 1, 4'd4,  0, 0, 0, 4'd2, 5'd7, 1, 1, 3'd4);
    vecs[13] = mkv(1, 5'd12, 0, 1, 0, 0, 4'd0,  0, 0, 0, 4'd2, 5'd7, 1, 1, 3'd4);
    // Ack edge -> IDLE, no new game on the same edge or while held
    vecs[14] = mkv(1, 5'd12, 1, 0, 0, 0, 4'd0,  0, 0, 0, 4'd0, 5'd0, 0, 0, 3'd0);
    vecs[15] = mkv(1, 5'd12, 1, 0, 0, 0, 4'd0,  0, 0, 0, 4'd0, 5'd0, 0, 0, 3'd0);
    vecs[16] = mkv(1, 5'd12, 0, 0, 0, 0, 4'd0,  0, 0, 0, 4'd0, 5'd0, 0, 0, 3'd0);
    // Loss with budget 2
    vecs[17] = mkv(1, 5'd2,  1, 0, 0, 0, 4'd0,  1, 0, 0, 4'd0, 5'd2, 0, 0, 3'd1);
    vecs[18] = mkv(1, 5'd2,  0, 1, 0, 0, 4'd0,  1, 0, 0, 4'd1, 5'd2, 0, 0, 3'd2);
    vecs[19] = mkv(1, 5'd2,  0, 1, 1, 0, 4'd0,  1, 1, 1, 4'd1, 5'd2, 0, 0, 3'd3);
    vecs[20] = mkv(1, 5'd2,  0, 1, 0, 1, 4'd1,  1, 0, 0, 4'd2, 5'd1, 0, 0, 3'd2);
    vecs[21] = mkv(1, 5'd2,  0, 1, 1, 0, 4'd0,  1, 1, 1, 4'd2, 5'd1, 0, 0, 3'd3);
    vecs[22] = mkv(1, 5'd2,  0, 1, 0, 1, 4'd1,  0, 0, 0, 4'd2, 5'd0, 0, 1, 3'd5);
    // Late GradeDone in LOSE ignored
    vecs[23] = mkv(1, 5'd2,  0, 1, 0, 1, 4'd4,  0, 0, 0, 4'd2, 5'd0, 0, 1, 3'd5);
    vecs[24] = mkv(1, 5'd2,  1, 0, 0, 0, 4'd0,  0, 0, 0, 4'd0, 5'd0, 0, 0, 3'd0);
    vecs[25] = mkv(1, 5'd2,  0, 0, 0, 0, 4'd0,  0, 0, 0, 4'd0, 5'd0, 0, 0, 3'd0);
    // Win on the final round of a 1-round budget, Znarly above NUM_SHAPES
    vecs[26] = mkv(1, 5'd1,  1, 0, 0, 0, 4'd0,  1, 0, 0, 4'd0, 5'd1, 0, 0, 3'd1);
    vecs[27] = mkv(1, 5'd1,  0, 1, 0, 0, 4'd0,  1, 0, 0, 4'd1, 5'd1, 0, 0, 3'd2);
    vecs[28] = mkv(1, 5'd1,  0, 1, 1, 0, 4'd0,  1, 1, 1, 4'd1, 5'd1, 0, 0, 3'd3);
    vecs[29] = mkv(1, 5'd1,  0, 1, 0, 1, 4'd15, 0, 0, 0, 4'd1, 5'd1, 1, 1, 3'd4);
    vecs[30] = mkv(1, 5'd1,  1, 0, 0, 0, 4'd0,  0, 0, 0, 4'd0, 5'd0, 0, 0, 3'd0);
    vecs[31] = mkv(1, 5'd1,  0, 0, 0, 0, 4'd0,  0, 0, 0, 4'd0, 5'd0, 0, 0, 3'd0);

    // Reset state
    reset = 1'b0;
    drive(0, 5'd0, 0, 0, 0, 0, 4'd0);
    tick();
    check("reset_state", 17'd0);
    @(negedge CLOCK_50);
    reset = 1'b1;
    tick();
    check("after_release", 17'd0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rr, vecs[i].nr, vecs[i].sb, vecs[i].pr, vecs[i].gs, vecs[i].gd, vecs[i].zn);
      tick();
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Asynchronous reset in the middle of GRADE
    drive(1, 5'd5, 1, 0, 0, 0, 4'd0);
    tick();
    check("ar_load", mk_exp(1, 0, 0, 4'd0, 5'd5, 0, 0, 3'd1));
    drive(1, 5'd5, 0, 1, 0, 0, 4'd0);
    tick();
    drive(1, 5'd5, 0, 1, 1, 0, 4'd0);
    tick();
    drive(1, 5'd5, 0, 1, 0, 1, 4'd0);
    tick();
    drive(1, 5'd5, 0, 1, 1, 0, 4'd0);
    tick();
    check("ar_grade", mk_exp(1, 1, 1, 4'd2, 5'd4, 0, 0, 3'd3));
    drive(1, 5'd5, 0, 0, 0, 0, 4'd0);
    #2;
    reset = 1'b0;
    #1;
    check("ar_immediate", 17'd0);
    #3;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("ar_quiet%0d", k), 17'd0);
    end
    drive(1, 5'd5, 1, 0, 0, 0, 4'd0);
    tick();
    check("ar_restart", mk_exp(1, 0, 0, 4'd0, 5'd5, 0, 0, 3'd1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
Top-level round controller for the Zoordian game. It gates game start on coin credit and waits for the master pattern to load. It then runs guess/grade rounds against the grader and declares a win or loss. It drives StartGame to the coin, pattern and grader blocks and sequences GradeIt. It owns the per-game round budget and the round counter.

Parameters:
MAX_ROUNDS, 8, cap on rounds per game; legal range 1..15.
NUM_SHAPES, 4, Znarly value (exact matches) that wins the game.

Ports:
CLOCK_50  input  1  system clock
reset  input  1  asynchronous, active-low reset
roundReady  input  1  coin block holds at least one credited round
NumRounds  input  5  credited rounds from coin block
StartButton  input  1  player start/acknowledge, level; block detects rising edge internally
patternReady  input  1  pattern loader has a complete master pattern
GuessSubmit  input  1  one-cycle pulse: player guess is valid
GradeDone  input  1  one-cycle pulse: grader result valid on Znarly
Znarly  input  4  exact-match count from grader
StartGame  output  1  game active, for downstream blocks
GradeIt  output  1  one-cycle grade request to grader
GuessAccept  output  1  one-cycle acknowledge of GuessSubmit
RoundNumber  output  4  current round, 1-based; 0 when idle
RoundsLeft  output  5  remaining rounds in this game
GameWon  output  1  game ended with a win
GameOver  output  1  game ended, win or loss
state  output  3  current FSM state, debug

Behaviour:
- All outputs are registered.
- reset low, asynchronously: state=IDLE; all outputs 0; start-edge detector history cleared. Reset mid-game aborts immediately with no end flags raised.
- Start edge: StartButton high this cycle and low in the previous sampled cycle.
- IDLE:
  - Start edge with roundReady=1 and NumRounds!=0 -> LOAD.
  - On that transition: RoundsLeft <= min(NumRounds, MAX_ROUNDS); StartGame <= 1.
  - Start edge without credit is ignored; stay in IDLE.
- LOAD:
  - StartGame=1; wait for patternReady=1.
  - On patternReady -> PLAY; RoundNumber <= 1.
  - GuessSubmit and GradeDone are ignored.
- PLAY:
  - On GuessSubmit -> GRADE.
  - GradeIt and GuessAccept are each 1 for exactly the next cycle (latency 1 from the sampled GuessSubmit).
  - GradeDone in PLAY is ignored.
- GRADE:
  - Wait for GradeDone. Further GuessSubmit is ignored and gets no GuessAccept.
  - On GradeDone with Znarly >= NUM_SHAPES -> WIN.
  - On GradeDone otherwise: RoundsLeft <= RoundsLeft-1.
    - If the old RoundsLeft was 1 -> LOSE.
    - Else RoundNumber <= RoundNumber+1 and return to PLAY.
  - A win on the final round is a WIN, not a LOSE.
- WIN: GameWon=1, GameOver=1, StartGame=0.
- LOSE: GameWon=0, GameOver=1, StartGame=0.
- WIN and LOSE hold RoundNumber and RoundsLeft frozen.
- In WIN/LOSE, a start edge -> IDLE. That transition clears GameWon, GameOver, RoundNumber and RoundsLeft. It does not start a new game in the same edge; a new edge is required in IDLE.
- Width rules: RoundsLeft never underflows (decrement only when >=1). RoundNumber never exceeds MAX_ROUNDS (<=15), so it never wraps.
- state encoding: IDLE=0, LOAD=1, PLAY=2, GRADE=3, WIN=4, LOSE=5. Other codes recover to IDLE.
- StartButton held high continuously produces a single edge only.

Test Plan:
- No credit: roundReady=0, NumRounds=0, pulse StartButton -> state stays IDLE; StartGame=0; all outputs 0.
- Budget clamp, load, first round:
  - Setup: NumRounds=12, MAX_ROUNDS=8, start edge.
  - Next cycle: StartGame=1, RoundsLeft=8, state=LOAD.
  - patternReady=1 -> state=PLAY, RoundNumber=1.
- Grade handshake:
  - In PLAY, GuessSubmit pulse -> GradeIt=1 and GuessAccept=1 for exactly one cycle; state=GRADE.
  - Second GuessSubmit in GRADE -> no GuessAccept.
  - GradeDone with Znarly=2 -> RoundNumber=2, RoundsLeft=7, state=PLAY.
- Win: GuessSubmit, then GradeDone with Znarly=4 -> GameWon=1, GameOver=1, StartGame=0; RoundsLeft unchanged.
  - Then start edge -> IDLE with all outputs 0.
- Loss with budget 2:
  - Setup: NumRounds=2; two guesses graded Znarly=1.
  - After round 1: RoundNumber=2, RoundsLeft=1.
  - After round 2: GameOver=1, GameWon=0, RoundsLeft=0, RoundNumber=2.
- Async reset mid-GRADE: drive reset=0 between clock edges -> state=IDLE and all outputs 0 immediately, without waiting for a clock edge. Release -> no activity until a new start edge.
